// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - serial pattern detector with match counter and target-based completion
// Define SEQ_DETECT_OVERLAP_EN to keep the fill count after a match (overlapping detection).
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             err
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIGURED,
    S_ARMED,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [3:0]         len_q, len_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               match_q, match_d;
  logic               err_q, err_d;

  logic               cfg_fire;
  logic               cfg_bad;
  logic [PAT_W-1:0]   len_mask;
  logic [PAT_W-1:0]   hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic [CNT_W-1:0]   count_inc;
  logic               hit;

  assign cfg_ready   = (state_q != S_ARMED);
  assign busy        = (state_q == S_ARMED);
  assign done        = (state_q == S_DONE);
  assign match       = match_q;
  assign match_count = count_q;
  assign err         = err_q;

  assign cfg_fire = cfg_valid && cfg_ready;
  assign cfg_bad  = (cfg_len == 4'd0) || (int'(cfg_len) > PAT_W);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // Compare against the history as it will look after this bit is shifted in.
  always_comb begin
    hist_shift    = hist_q << 1;
    hist_shift[0] = bit_in;
    fill_inc      = (int'(fill_q) < PAT_W) ? fill_q + 1'b1 : fill_q;
    count_inc     = (count_q == '1) ? count_q : count_q + 1'b1;
    hit           = (((hist_shift ^ pat_q) & len_mask) == '0) &&
                    (int'(fill_inc) >= int'(len_q));
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    target_d = target_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    count_d  = count_q;
    err_d    = err_q;
    match_d  = 1'b0;

    if (cfg_fire) begin
      if (cfg_bad) begin
        err_d = 1'b1;
      end else begin
        pat_d    = cfg_pattern;
        len_d    = cfg_len;
        target_d = cfg_target;
        err_d    = 1'b0;
        state_d  = S_CONFIGURED;
      end
    end else if (start && (state_q == S_CONFIGURED || state_q == S_DONE)) begin
      state_d = S_ARMED;
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (state_q == S_ARMED) begin
      if (abort) begin
        state_d = S_CONFIGURED;
      end else if (bit_valid) begin
        hist_d = hist_shift;
        fill_d = fill_inc;
        if (hit) begin
          match_d = 1'b1;
          count_d = count_inc;
`ifdef SEQ_DETECT_OVERLAP_EN
          fill_d  = fill_inc;
`else
          fill_d  = '0;
`endif
          if ((target_q != '0) && (count_inc == target_q)) begin
            state_d = S_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      target_q <= '0;
      hist_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      target_q <= target_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      match_q  <= match_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed bench for seq_detect_ctrl with a match/count scoreboard
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
`ifdef SEQ_DETECT_OVERLAP_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [3:0]       cfg_len = '0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             done;
  logic             err;

  int tests = 0;
  int fails = 0;
  logic [CNT_W:0] sb_q[$];

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
    .start(start), .abort(abort),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy), .match(match), .match_count(match_count),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] pat, input logic [3:0] len,
                        input logic [CNT_W-1:0] tgt);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_target = tgt;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic exp_m, input logic [CNT_W-1:0] exp_cnt);
    logic [CNT_W:0] exp;
    bit_valid = 1'b1;
    bit_in    = b;
    sb_q.push_back({exp_m, exp_cnt});
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    exp = sb_q.pop_front();
    chk("match", {31'd0, match}, {31'd0, exp[CNT_W]});
    chk("match_count", {24'd0, match_count}, {24'd0, exp[CNT_W-1:0]});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_match"}, {31'd0, match}, 32'd0);
    chk({tag, "_count"}, {24'd0, match_count}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) step();
    chk_reset_outputs("reset");
    reset = 1'b0;
    step();

    do_start();
    chk("start_in_idle_busy", {31'd0, busy}, 32'd0);

    do_cfg(8'h06, 4'd0, 8'd0);
    chk("len0_err", {31'd0, err}, 32'd1);
    do_start();
    chk("len0_still_idle", {31'd0, busy}, 32'd0);
    do_cfg(8'h06, 4'd9, 8'd0);
    chk("len9_err", {31'd0, err}, 32'd1);
    do_cfg(8'h06, 4'd4, 8'd0);
    chk("legal_err_clear", {31'd0, err}, 32'd0);
    do_start();
    chk("armed_busy", {31'd0, busy}, 32'd1);
    chk("armed_cfg_ready", {31'd0, cfg_ready}, 32'd0);

    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b1, 8'd1);
    step();
    chk("pulse_one_cycle", {31'd0, match}, 32'd0);
    do_start();
    chk("start_in_armed_ignored", {24'd0, match_count}, 32'd1);
    do_abort();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_count_kept", {24'd0, match_count}, 32'd1);

    do_start();
    chk("restart_count_clr", {24'd0, match_count}, 32'd0);
    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b1, 8'd1);
    send_bit(1'b1, 1'b0, 8'd1);
    send_bit(1'b1, 1'b0, 8'd1);
    send_bit(1'b0, OV, OV ? 8'd2 : 8'd1);

    do_abort();
    do_start();
    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b1, 8'd1);
    send_bit(1'b0, 1'b0, 8'd1);
    send_bit(1'b1, 1'b0, 8'd1);
    send_bit(1'b1, 1'b0, 8'd1);
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    step();
    abort = 1'b0; bit_valid = 1'b0;
    chk("abort_bit_no_match", {31'd0, match}, 32'd0);
    chk("abort_bit_count", {24'd0, match_count}, 32'd1);
    chk("abort_bit_configured", {31'd0, cfg_ready & ~busy}, 32'd1);
    send_bit(1'b0, 1'b0, 8'd1);

    do_cfg(8'h06, 4'd4, 8'd2);
    chk("tgt_cfg_done", {31'd0, done}, 32'd0);
    do_start();
    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b1, 8'd1);
    chk("tgt_first_not_done", {31'd0, done}, 32'd0);
    send_bit(1'b0, 1'b0, 8'd1);
    send_bit(1'b1, 1'b0, 8'd1);
    send_bit(1'b1, 1'b0, 8'd1);
    send_bit(1'b0, 1'b1, 8'd2);
    chk("tgt_done", {31'd0, done}, 32'd1);
    chk("tgt_busy", {31'd0, busy}, 32'd0);
    send_bit(1'b0, 1'b0, 8'd2);
    send_bit(1'b1, 1'b0, 8'd2);
    send_bit(1'b1, 1'b0, 8'd2);
    send_bit(1'b0, 1'b0, 8'd2);
    chk("tgt_done_held", {31'd0, done}, 32'd1);

    cfg_valid = 1'b1; cfg_pattern = 8'h06; cfg_len = 4'd4; cfg_target = 8'd0; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk("cfg_start_busy", {31'd0, busy}, 32'd0);
    chk("cfg_start_done_clr", {31'd0, done}, 32'd0);
    chk("cfg_start_count", {24'd0, match_count}, 32'd2);
    do_cfg(8'h06, 4'd9, 8'd0);
    chk("bad_cfg_in_cfgd_err", {31'd0, err}, 32'd1);
    do_start();
    chk("bad_cfg_kept_state", {31'd0, busy}, 32'd1);

    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    step();
    chk("reset_held_match", {31'd0, match}, 32'd0);
    reset = 1'b0;
    do_start();
    chk("post_reset_idle", {31'd0, busy}, 32'd0);
    do_cfg(8'h06, 4'd4, 8'd0);
    chk("post_reset_err", {31'd0, err}, 32'd0);
    do_start();
    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b1, 8'd1);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
